// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: field polynomial, mode encodings, FSM states
// and the GF(2^8) doubling helper used by the column transform.
package aes_pkg;

  localparam logic [7:0] GF_POLY = 8'h1b;
  localparam int COL_W = 32;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column (row 0 in the MSB).
module mix_column_unit
  import aes_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic             mode,
  input  logic [COL_W-1:0] col,
  output logic [COL_W-1:0] res
);

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] fwd[4];
  logic [7:0] inv[4];
  logic       use_inv;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
  end

  // Row r uses coefficients rotated right by r: fwd {2,3,1,1}, inv {e,b,d,9}.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      fwd[r] = x2[r] ^ x2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
      inv[r] = 8'h00;
      if (INV_EN) begin
        inv[r] = (x8[r] ^ x4[r] ^ x2[r])
               ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
               ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
               ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
      end
    end
  end

  assign use_inv = INV_EN && (mode == MODE_INV);

  always_comb begin
    res = '0;
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = use_inv ? inv[r] : fwd[r];
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns engine: accepts an NB-column state, transforms
// COLS_PER_CYCLE columns per clock, then holds the result until taken.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int NB             = 4,
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [32*NB-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_data
);

  localparam int N     = NB / COLS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4) ||
        (NB % COLS_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4 and divide NB");
    end
  endgenerate

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid is held by its source until then, and data is stable with it.

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               mode_q;
  logic [32*NB-1:0]   work;
  logic [32*NB-1:0]   work_nxt;
  logic [COL_W-1:0]   grp_in [COLS_PER_CYCLE];
  logic [COL_W-1:0]   grp_out[COLS_PER_CYCLE];
  int                 grp_base;

  assign grp_base = (N > 1) ? int'(cnt) * COLS_PER_CYCLE : 0;

  always_comb begin
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      grp_in[g] = work[(grp_base + g)*COL_W +: COL_W];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
    mix_column_unit #(.INV_EN(INV_EN)) u_col (
      .mode (mode_q),
      .col  (grp_in[g]),
      .res  (grp_out[g])
    );
  end

  // Only the selected column group changes; the rest pass through.
  always_comb begin
    work_nxt = work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_nxt[(grp_base + g)*COL_W +: COL_W] = grp_out[g];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= MODE_FWD;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            mode_q   <= INV_EN ? in_mode : MODE_FWD;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          work <= work_nxt;
          if (cnt == CNT_W'(N - 1)) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = work;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: four configurations (CPC 1/2/4, inverse removed)
// checked against a GF(2^8) matrix-multiply reference model.
module tb_mix_columns_seq;

  localparam int CPC_T[4] = '{1, 2, 4, 1};
  localparam int INV_T[4] = '{1, 1, 1, 0};

  localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] INV_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid [4];
  logic         in_ready [4];
  logic         in_mode  [4];
  logic         out_valid[4];
  logic         out_ready[4];
  logic [127:0] in_data  [4];
  logic [127:0] out_data [4];

  logic [127:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mix_columns_seq #(
      .NB             (4),
      .COLS_PER_CYCLE (CPC_T[g]),
      .INV_EN         (INV_T[g] != 0)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_mode   (in_mode[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );
  end

  // reference model
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] aa;
    logic [7:0] p;
    p  = 8'h00;
    aa = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] d, input bit inv);
    logic [7:0]   row0[4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(row0[(j - i + 4) % 4], d[32*c + 31 - 8*j -: 8]);
        end
        r[32*c + 31 - 8*i -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at the falling edge right after the accept edge.
  task automatic wait_result(input int k);
    int cyc;
    logic [127:0] exp;
    cyc = 0;
    while (!out_valid[k] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq($sformatf("latency_dut%0d", k), 128'(cyc), 128'(4 / CPC_T[k]));
    exp = exp_q.pop_front();
    check_eq($sformatf("data_dut%0d", k), out_data[k], exp);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    check_eq($sformatf("valid_clr_dut%0d", k), 128'(out_valid[k]), 128'(0));
    check_eq($sformatf("ready_set_dut%0d", k), 128'(in_ready[k]), 128'(1));
  endtask

  // driver
  task automatic run_block(input int k, input logic [127:0] d, input logic m,
                           input logic [127:0] exp);
    @(negedge clk);
    check_eq($sformatf("in_ready_dut%0d", k), 128'(in_ready[k]), 128'(1));
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_mode[k]  = m;
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_data[k]  = {$urandom, $urandom, $urandom, $urandom};
    wait_result(k);
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] d2;
    logic         m;
    int           cyc;

    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; in_mode[k] = 1'b0; out_ready[k] = 1'b0; in_data[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rst_in_ready_%0d", k), 128'(in_ready[k]), 128'(1));
      check_eq($sformatf("rst_out_valid_%0d", k), 128'(out_valid[k]), 128'(0));
      check_eq($sformatf("rst_out_data_%0d", k), out_data[k], 128'(0));
    end
    rst = 1'b0;

    // Directed vectors; the inverse-less build must perform forward on mode 1.
    for (int k = 0; k < 3; k++) begin
      run_block(k, FWD_IN, 1'b0, FWD_OUT);
      run_block(k, INV_IN, 1'b1, INV_OUT);
    end
    run_block(3, FWD_IN, 1'b1, FWD_OUT);

    // Randomized blocks against the model.
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 6; n++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        m = 1'($urandom_range(0, 1));
        run_block(k, d, m, mix_ref(d, m && (INV_T[k] != 0)));
      end
    end

    // Backpressure on the CPC=1 build.
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = FWD_IN; in_mode[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    cyc = 0;
    while (!out_valid[0] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("bp_latency", 128'(cyc), 128'(4));
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
      in_mode[0]  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("bp_valid", 128'(out_valid[0]), 128'(1));
      check_eq("bp_data", out_data[0], FWD_OUT);
      check_eq("bp_in_ready", 128'(in_ready[0]), 128'(0));
    end
    d2 = {$urandom, $urandom, $urandom, $urandom};
    in_data[0] = d2; in_mode[0] = 1'b1; out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check_eq("bp_release_valid", 128'(out_valid[0]), 128'(0));
    check_eq("bp_release_ready", 128'(in_ready[0]), 128'(1));
    @(negedge clk);
    in_valid[0] = 1'b0;
    check_eq("bp_next_accepted", 128'(in_ready[0]), 128'(0));
    exp_q.push_back(mix_ref(d2, 1'b1));
    wait_result(0);

    // Reset two column cycles into a block.
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = INV_IN; in_mode[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", 128'(out_valid[0]), 128'(0));
    check_eq("midrst_in_ready", 128'(in_ready[0]), 128'(1));
    check_eq("midrst_out_data", out_data[0], 128'(0));
    @(negedge clk);
    rst = 1'b0;
    run_block(0, FWD_IN, 1'b0, FWD_OUT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
